// File: rtl/axi_sram_responder_pkg.sv
// rtl/axi_sram_responder_pkg.sv - AXI response/burst types and responder state shared by the SRAM responder
package axi_sram_responder_pkg;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } axi_resp_t;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'b00,
      BURST_INCR  = 2'b01,
      BURST_WRAP  = 2'b10
   } axi_burst_t;

   typedef enum logic [1:0] {
      IDLE,
      RD_BURST,
      WR_DATA,
      WR_RESP
   } rsp_state_t;

   localparam logic [2:0] AXI_SIZE_4B = 3'b010;

   // Request-level response: protocol-shape errors outrank address decode errors.
   function automatic axi_resp_t req_resp(input logic [2:0] size, input logic [1:0] burst,
                                          input logic [7:0] len, input int unsigned max_len,
                                          input logic hi_nz);
      if (size != AXI_SIZE_4B || burst == BURST_WRAP || burst == 2'b11 || 32'(len) > max_len)
         return RESP_SLVERR;
      if (hi_nz)
         return RESP_DECERR;
      return RESP_OKAY;
   endfunction

endpackage

// File: rtl/axi_sram_mem.sv
// rtl/axi_sram_mem.sv - single-port byte-enable synchronous SRAM, one-cycle read latency
module axi_sram_mem #(
   parameter int MEM_WORDS_W = 14
) (
   input  logic                   clk,
   input  logic                   en,
   input  logic                   we,
   input  logic [3:0]             be,
   input  logic [MEM_WORDS_W-1:0] addr,
   input  logic [31:0]            wdata,
   output logic [31:0]            rdata
);

   logic [31:0] mem [0:(1<<MEM_WORDS_W)-1];

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int i = 0; i < 4; i++) begin
               if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
         end else begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/axi_sram_responder.sv
// rtl/axi_sram_responder.sv - AXI4 SRAM responder, one transaction at a time; AXI_SRAM_ERR_CHECK_EN enables
// SLVERR/DECERR checking.
module axi_sram_responder
   import axi_sram_responder_pkg::*;
#(
   parameter int MEM_WORDS_W = 14,
   parameter int MAX_LEN     = 31
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        axi_arvalid,
   output logic        axi_arready,
   input  logic [31:0] axi_araddr,
   input  logic [7:0]  axi_arlen,
   input  logic [2:0]  axi_arsize,
   input  logic [1:0]  axi_arburst,
   input  logic [5:0]  axi_arid,
   input  logic [2:0]  axi_arprot,
   input  logic [3:0]  axi_arcache,
   output logic        axi_rvalid,
   input  logic        axi_rready,
   output logic [31:0] axi_rdata,
   output logic [1:0]  axi_rresp,
   output logic        axi_rlast,
   output logic [5:0]  axi_rid,
   input  logic        axi_awvalid,
   output logic        axi_awready,
   input  logic [31:0] axi_awaddr,
   input  logic [7:0]  axi_awlen,
   input  logic [2:0]  axi_awsize,
   input  logic [1:0]  axi_awburst,
   input  logic [2:0]  axi_awprot,
   input  logic [3:0]  axi_awcache,
   input  logic        axi_wvalid,
   output logic        axi_wready,
   input  logic [31:0] axi_wdata,
   input  logic [3:0]  axi_wstrb,
   input  logic        axi_wlast,
   output logic        axi_bvalid,
   input  logic        axi_bready,
   output logic [1:0]  axi_bresp
);

   localparam int IW = MEM_WORDS_W;

   rsp_state_t     state;
   logic           prio_w;
   logic [IW-1:0]  addr_q;
   logic [7:0]     len_q;
   logic           fixed_q;
   logic [8:0]     beat_q;
   logic [7:0]     rbeat_q;
   logic [5:0]     id_q;
   axi_resp_t      resp_q;
   logic           wlast_err_q;
   logic           bvalid_q;
   logic           rd_pend;
   logic [31:0]    fifo_q [2];
   logic           fifo_wp, fifo_rp;
   logic [1:0]     fifo_cnt;
   logic [31:0]    mem_rdata;

   logic           grant_w, ar_hs, aw_hs, w_hs, r_pop, rd_room, rd_issue;
   logic [IW-1:0]  ar_idx, aw_idx;
   axi_resp_t      ar_resp, aw_resp;
   logic           ar_fixed, aw_fixed, wlast_bad;
   logic           unused_ok;

   assign ar_idx = axi_araddr[IW+1:2];
   assign aw_idx = axi_awaddr[IW+1:2];

`ifdef AXI_SRAM_ERR_CHECK_EN
   assign ar_resp   = req_resp(axi_arsize, axi_arburst, axi_arlen, MAX_LEN, |(axi_araddr >> (IW+2)));
   assign aw_resp   = req_resp(axi_awsize, axi_awburst, axi_awlen, MAX_LEN, |(axi_awaddr >> (IW+2)));
   assign ar_fixed  = axi_arburst == BURST_FIXED;
   assign aw_fixed  = axi_awburst == BURST_FIXED;
   assign wlast_bad = w_hs && (axi_wlast != (beat_q[7:0] == len_q));
`else
   logic unused_cfg;
   assign ar_resp    = RESP_OKAY;
   assign aw_resp    = RESP_OKAY;
   assign ar_fixed   = 1'b0;
   assign aw_fixed   = 1'b0;
   assign wlast_bad  = 1'b0;
   assign unused_cfg = ^{axi_araddr[31:IW+2], axi_awaddr[31:IW+2], axi_arsize, axi_arburst,
                         axi_awsize, axi_awburst, axi_wlast, 8'(MAX_LEN)};
`endif
   assign unused_ok = ^{axi_araddr[1:0], axi_awaddr[1:0], axi_arprot, axi_arcache, axi_awprot, axi_awcache};

   // Ready lines are qualified by rst so they fall the instant reset is asserted.
   assign grant_w     = axi_awvalid && (!axi_arvalid || prio_w);
   assign axi_awready = rst && state == IDLE && grant_w;
   assign axi_arready = rst && state == IDLE && axi_arvalid && !grant_w;
   assign axi_wready  = rst && state == WR_DATA;
   assign ar_hs       = axi_arvalid && axi_arready;
   assign aw_hs       = axi_awvalid && axi_awready;
   assign w_hs        = axi_wvalid && axi_wready;
   assign r_pop       = axi_rvalid && axi_rready;

   // First beat is fetched during the AR handshake so data reaches the FIFO one cycle later.
   assign rd_room  = ({1'b0, fifo_cnt} + {2'b0, rd_pend} - {2'b0, r_pop}) < 3'd2;
   assign rd_issue = ar_hs || (state == RD_BURST && beat_q <= {1'b0, len_q} && rd_room);

   axi_sram_mem #(.MEM_WORDS_W(IW)) u_mem (
      .clk   (clk),
      .en    (rd_issue || w_hs),
      .we    (w_hs),
      .be    (resp_q == RESP_OKAY ? axi_wstrb : 4'h0),
      .addr  (ar_hs ? ar_idx : addr_q),
      .wdata (axi_wdata),
      .rdata (mem_rdata)
   );

   assign axi_rvalid = fifo_cnt != 2'd0;
   assign axi_rdata  = axi_rvalid ? fifo_q[fifo_rp] : 32'h0;
   assign axi_rlast  = axi_rvalid && rbeat_q == len_q;
   assign axi_rid    = axi_rvalid ? id_q : 6'h0;
   assign axi_rresp  = axi_rvalid ? resp_q : RESP_OKAY;
   assign axi_bvalid = bvalid_q;
   assign axi_bresp  = !bvalid_q ? RESP_OKAY :
                       resp_q != RESP_OKAY ? resp_q :
                       wlast_err_q ? RESP_SLVERR : RESP_OKAY;

   always_ff @(posedge clk) begin
      if (rd_pend) fifo_q[fifo_wp] <= (resp_q == RESP_OKAY) ? mem_rdata : 32'h0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         prio_w      <= 1'b1;
         addr_q      <= '0;
         len_q       <= '0;
         fixed_q     <= 1'b0;
         beat_q      <= '0;
         rbeat_q     <= '0;
         id_q        <= '0;
         resp_q      <= RESP_OKAY;
         wlast_err_q <= 1'b0;
         bvalid_q    <= 1'b0;
         rd_pend     <= 1'b0;
         fifo_wp     <= 1'b0;
         fifo_rp     <= 1'b0;
         fifo_cnt    <= '0;
      end else begin
         rd_pend  <= rd_issue;
         fifo_cnt <= fifo_cnt + {1'b0, rd_pend} - {1'b0, r_pop};
         if (rd_pend) fifo_wp <= ~fifo_wp;
         if (r_pop) fifo_rp <= ~fifo_rp;
         // Priority only alternates when both channels actually contended for the grant.
         if ((aw_hs || ar_hs) && axi_awvalid && axi_arvalid) prio_w <= ~prio_w;
         case (state)
            IDLE: begin
               if (aw_hs) begin
                  state       <= WR_DATA;
                  addr_q      <= aw_idx;
                  len_q       <= axi_awlen;
                  fixed_q     <= aw_fixed;
                  beat_q      <= '0;
                  resp_q      <= aw_resp;
                  wlast_err_q <= 1'b0;
               end else if (ar_hs) begin
                  state   <= RD_BURST;
                  addr_q  <= ar_fixed ? ar_idx : ar_idx + IW'(1);
                  len_q   <= axi_arlen;
                  fixed_q <= ar_fixed;
                  beat_q  <= 9'd1;
                  rbeat_q <= '0;
                  id_q    <= axi_arid;
                  resp_q  <= ar_resp;
               end
            end
            RD_BURST: begin
               if (rd_issue) begin
                  beat_q <= beat_q + 9'd1;
                  if (!fixed_q) addr_q <= addr_q + IW'(1);
               end
               if (r_pop) begin
                  rbeat_q <= rbeat_q + 8'd1;
                  if (rbeat_q == len_q) state <= IDLE;
               end
            end
            WR_DATA: begin
               if (w_hs) begin
                  beat_q <= beat_q + 9'd1;
                  if (!fixed_q) addr_q <= addr_q + IW'(1);
                  if (wlast_bad) wlast_err_q <= 1'b1;
                  if (beat_q[7:0] == len_q) begin
                     state    <= WR_RESP;
                     bvalid_q <= 1'b1;
                  end
               end
            end
            WR_RESP: begin
               if (axi_bready) begin
                  bvalid_q <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
